i2c_responder: RTL and testbench

I2C_RESPONDER -- requirements
Module: i2c_responder

---
 rtl/i2c_responder.sv | 195 +++++++++++++++++++
 tb/tb_i2c_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_responder.sv
// I2C target (responder) for a single fixed 7-bit address, oversampled on clk.
// Handles write and read transfers, repeated START and STOP; no clock stretching.
module i2c_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WRITE_ACK = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] READ_ACK  = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic       scl_s1, scl_s2, scl_p;
  logic       sda_s1, sda_s2, sda_p;
  logic       scl_rise, scl_fall, scl_high;
  logic       start_det, stop_det;
  logic       load_tx;

  logic [2:0] state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       rw;
  logic       ack_seen;

  // Synchronizers reset to 1 so an idle bus produces no edges out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_p  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_p  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_p  <= sda_s2;
    end
  end

  always_comb begin
    scl_rise  = scl_s2 & ~scl_p;
    scl_fall  = ~scl_s2 & scl_p;
    scl_high  = scl_s2 & scl_p;
    start_det = scl_high & sda_p & ~sda_s2;
    stop_det  = scl_high & ~sda_p & sda_s2;
  end

  // tx_data is captured on the falling edge that ends an acknowledged slot.
  always_comb begin
    load_tx = 1'b0;
    if (scl_fall) begin
      if (state == ADDR_ACK && sda_oe && rw)
        load_tx = 1'b1;
      else if (state == READ_ACK && ack_seen)
        load_tx = 1'b1;
    end
    tx_req = rst_n & load_tx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      ack_seen <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        bitcnt   <= '0;
        sda_oe   <= 1'b0;
        ack_seen <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        ack_seen <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg  <= {shreg[6:0], sda_s2};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                rw <= sda_s2;
                if (shreg[6:0] == SLAVE_ADDR) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end

          // sda_oe doubles as the ACK phase flag: set on the first fall, cleared on the second.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                shreg  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= WRITE;
              end
            end
          end

          WRITE: begin
            if (scl_rise) begin
              shreg  <= {shreg[6:0], sda_s2};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                rx_data  <= {shreg[6:0], sda_s2};
                rx_valid <= 1'b1;
                state    <= WRITE_ACK;
              end
            end
          end

          WRITE_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= WRITE;
              end
            end
          end

          READ: begin
            if (scl_rise)
              bitcnt <= bitcnt + 3'd1;
            if (scl_fall) begin
              if (bitcnt == 3'd0) begin
                sda_oe   <= 1'b0;
                ack_seen <= 1'b0;
                state    <= READ_ACK;
              end else begin
                shreg  <= {shreg[6:0], shreg[7]};
                sda_oe <= ~shreg[6];
              end
            end
          end

          READ_ACK: begin
            if (scl_rise) begin
              if (!sda_s2)
                ack_seen <= 1'b1;
              else
                state <= WAIT_STOP;
            end
            if (scl_fall && ack_seen) begin
              shreg    <= tx_data;
              sda_oe   <= ~tx_data[7];
              ack_seen <= 1'b0;
              state    <= READ;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Scoreboarded bench: a bit-level I2C master drives the bus, expected bytes are
// queued by a transaction-level model and popped by an output monitor.
module tb_i2c_responder;

  localparam logic [6:0] ADDR = 7'h42;
  localparam int unsigned Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       sda_bus;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_responder #(.SLAVE_ADDR(ADDR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_exp[$];
  int         tx_exp[$];
  logic [7:0] last_rx = 8'h00;
  logic       oe_forbid = 1'b0;
  int         oe_viol = 0;
  logic [7:0] payload[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid: pulse with rx_data=%02h, none expected", rx_data);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_data", {24'h0, rx_data}, {24'h0, e});
        end
      end
      if (tx_req) begin
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_req: pulse seen, none expected");
        end else begin
          void'(tx_exp.pop_front());
        end
      end
      if (oe_forbid && sda_oe) oe_viol++;
    end
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic do_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic do_bit(input logic b, output logic r);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait();
    r = sda_bus;  qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int unsigned i = 0; i < 8; i++) do_bit(b[7-i], r);
    do_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_bits(output logic [7:0] v);
    logic r;
    v = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      do_bit(1'b1, r);
      v = {v[6:0], r};
    end
  endtask

  // One transfer: START (or Sr), address, n data bytes from payload, optional STOP.
  task automatic xfer(input logic [6:0] a, input logic rd, input int unsigned n,
                      input logic stop_after);
    logic       ack, r, match, last;
    logic [7:0] v;
    match = (a == ADDR);
    do_start();
    oe_viol   = 0;
    oe_forbid = ~match;
    if (match && rd) begin
      tx_data = payload[0];
      tx_exp.push_back(0);
    end
    write_byte({a, rd}, ack);
    chk("addr_ack", {31'h0, ack}, {31'h0, match});
    chk("busy_after_addr", {31'h0, busy}, {31'h0, match});
    for (int unsigned k = 0; k < n; k++) begin
      if (!rd) begin
        if (match) begin
          rx_exp.push_back(payload[k]);
          last_rx = payload[k];
        end
        write_byte(payload[k], ack);
        chk("data_ack", {31'h0, ack}, {31'h0, match});
      end else begin
        read_bits(v);
        chk("read_data", {24'h0, v}, {24'h0, (match ? payload[k] : 8'hFF)});
        last = (k == n - 1);
        if (!last && match) begin
          tx_data = payload[k+1];
          tx_exp.push_back(int'(k) + 1);
        end
        do_bit(last, r);
      end
    end
    if (rd) chk("oe_after_nack", {31'h0, sda_oe}, 32'h0);
    oe_forbid = 1'b0;
    if (!match) chk("oe_never_on_mismatch", oe_viol, 0);
    chk("rx_pending", rx_exp.size(), 0);
    chk("tx_pending", tx_exp.size(), 0);
    if (stop_after) begin
      do_stop();
      chk("busy_after_stop", {31'h0, busy}, 32'h0);
      chk("oe_after_stop", {31'h0, sda_oe}, 32'h0);
    end
  endtask

  initial begin
    logic       ack, r, stopped;
    logic [7:0] b;
    logic [6:0] a;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_tx_req", {31'h0, tx_req}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
    rst_n = 1'b1;
    qwait();

    // Write 0x5A
    payload[0] = 8'h5A;
    xfer(ADDR, 1'b0, 1, 1'b1);
    chk("write_rx_data", {24'h0, rx_data}, 32'h5A);

    // Read C3 (master ACK) then 3C (master NACK)
    payload[0] = 8'hC3;
    payload[1] = 8'h3C;
    xfer(ADDR, 1'b1, 2, 1'b1);

    // Address mismatch
    payload[0] = 8'hFF;
    xfer(7'h48, 1'b0, 1, 1'b1);
    chk("mismatch_rx_data", {24'h0, rx_data}, {24'h0, last_rx});

    // Write then repeated START into a read
    payload[0] = 8'h11;
    xfer(ADDR, 1'b0, 1, 1'b0);
    chk("sr_rx_data", {24'h0, rx_data}, 32'h11);
    payload[0] = 8'h6D;
    xfer(ADDR, 1'b1, 1, 1'b1);

    // Reset while the responder is ACKing a written byte
    do_start();
    write_byte({ADDR, 1'b0}, ack);
    chk("rst_test_addr_ack", {31'h0, ack}, 32'h1);
    b = 8'h96;
    rx_exp.push_back(b);
    for (int unsigned i = 0; i < 8; i++) do_bit(b[7-i], r);
    sda_m = 1'b1;
    qwait();
    chk("ack_driven_before_rst", {31'h0, sda_oe}, 32'h1);
    scl_m = 1'b1;
    qwait();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("oe_released_by_rst", {31'h0, sda_oe}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rx = 8'h00;
    chk("rx_data_after_rst", {24'h0, rx_data}, 32'h0);
    chk("busy_after_rst", {31'h0, busy}, 32'h0);
    scl_m = 1'b0;
    qwait();
    oe_viol = 0;
    oe_forbid = 1'b1;
    write_byte(8'h33, ack);
    chk("ignored_after_rst_ack", {31'h0, ack}, 32'h0);
    do_stop();
    oe_forbid = 1'b0;
    chk("ignored_after_rst_oe", oe_viol, 0);
    chk("ignored_after_rst_rx", {24'h0, rx_data}, 32'h0);

    // STOP after four bits of a data byte
    payload[0] = 8'hE7;
    xfer(ADDR, 1'b0, 1, 1'b1);
    do_start();
    write_byte({ADDR, 1'b0}, ack);
    chk("stop_mid_addr_ack", {31'h0, ack}, 32'h1);
    b = 8'hA5;
    for (int unsigned i = 0; i < 4; i++) do_bit(b[7-i], r);
    do_stop();
    chk("stop_mid_busy", {31'h0, busy}, 32'h0);
    chk("stop_mid_rx_data", {24'h0, rx_data}, {24'h0, last_rx});

    // Randomized transfers
    stopped = 1'b1;
    for (int unsigned t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
      for (int unsigned k = 0; k < 4; k++) payload[k] = 8'($urandom);
      stopped = ($urandom_range(0, 3) != 0);
      xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), stopped);
    end
    if (!stopped) do_stop();

    qwait();
    chk("final_rx_data", {24'h0, rx_data}, {24'h0, last_rx});
    chk("final_busy", {31'h0, busy}, 32'h0);
    chk("final_rx_pending", rx_exp.size(), 0);
    chk("final_tx_pending", tx_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
